// File: rtl/acc_stream_tx.sv
// acc_stream_tx: captures one parallel batch of ACC_WIDTH words and replays it
// as a ready/valid word stream in index order. A new batch may be captured
// in the same cycle that the last word of the current batch transfers, so
// consecutive batches stream with no idle cycle between them.
module acc_stream_tx #(
  parameter int ACC_WIDTH  = 4,
  parameter int DATA_WIDTH = 16,
  localparam int IDX_W     = (ACC_WIDTH > 1) ? $clog2(ACC_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  batch_valid_i,
  output logic                  batch_ready_o,
  input  logic [DATA_WIDTH-1:0] batch_data_i [0:ACC_WIDTH-1],
  output logic                  stream_valid_o,
  input  logic                  stream_ready_i,
  output logic [DATA_WIDTH-1:0] stream_data_o,
  output logic [IDX_W-1:0]      stream_idx_o,
  output logic                  stream_last_o,
  output logic                  busy_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_WIDTH - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   buf_q [0:ACC_WIDTH-1];
  logic                    load_d;
  logic                    xfer;
  logic                    accept;

  // State and word index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Batch buffer: written only when a batch is accepted, so input changes
  // while streaming never reach the emitted words.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ACC_WIDTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (load_d) begin
      for (int i = 0; i < ACC_WIDTH; i++) begin
        buf_q[i] <= batch_data_i[i];
      end
    end
  end

  // Stream outputs, handshakes and next-state selection.
  always_comb begin
    stream_valid_o = 1'b0;
    stream_data_o  = '0;
    stream_idx_o   = '0;
    stream_last_o  = 1'b0;
    busy_o         = 1'b0;
    state_d        = state_q;
    idx_d          = idx_q;
    load_d         = 1'b0;

    if (state_q == STREAM) begin
      stream_valid_o = 1'b1;
      stream_data_o  = buf_q[idx_q];
      stream_idx_o   = idx_q;
      stream_last_o  = (idx_q == LAST_IDX);
      busy_o         = 1'b1;
    end

    xfer = stream_valid_o && stream_ready_i;
    // Ready also opens on the transfer of the last word, which gives the
    // intended combinational path from stream_ready_i for zero-bubble chaining.
    batch_ready_o = !rst && ((state_q == IDLE) || (xfer && stream_last_o));
    accept        = batch_valid_i && batch_ready_o;

    if (accept) begin
      state_d = STREAM;
      idx_d   = '0;
      load_d  = 1'b1;
    end else if (xfer) begin
      if (stream_last_o) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_acc_stream_tx.sv
// Bench for acc_stream_tx: directed scenarios plus randomized batches and
// backpressure on a 4-word instance, and a 1-word/8-bit instance. A queue
// of expected words is filled on every batch handshake and drained by a
// monitor on every word handshake.
module tb_acc_stream_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-word, 16-bit instance
  logic        bv = 1'b0;
  logic        br;
  logic [15:0] bd  [0:3];
  logic [15:0] nxt [0:3];
  logic        sv;
  logic        sr = 1'b0;
  logic [15:0] sd;
  logic [1:0]  si;
  logic        sl;
  logic        busy;

  // 1-word, 8-bit instance
  logic        bv1 = 1'b0;
  logic        br1;
  logic [7:0]  bd1 [0:0];
  logic        sv1;
  logic        sr1 = 1'b0;
  logic [7:0]  sd1;
  logic [0:0]  si1;
  logic        sl1;
  logic        busy1;

  acc_stream_tx #(.ACC_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .batch_valid_i(bv), .batch_ready_o(br), .batch_data_i(bd),
    .stream_valid_o(sv), .stream_ready_i(sr), .stream_data_o(sd),
    .stream_idx_o(si), .stream_last_o(sl), .busy_o(busy)
  );

  acc_stream_tx #(.ACC_WIDTH(1), .DATA_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst),
    .batch_valid_i(bv1), .batch_ready_o(br1), .batch_data_i(bd1),
    .stream_valid_o(sv1), .stream_ready_i(sr1), .stream_data_o(sd1),
    .stream_idx_o(si1), .stream_last_o(sl1), .busy_o(busy1)
  );

  typedef struct {
    logic [15:0] d;
    int          idx;
    bit          last;
  } ent_t;

  ent_t q[$];
  ent_t q1[$];
  int   total = 0;
  int   bad   = 0;
  int   words1 = 0;
  bit   done  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor, 4-word instance. Sampled at the falling edge, when
  // the inputs for the coming rising edge are already stable.
  always @(negedge clk) begin
    ent_t e;
    bit   exp_rdy;
    exp_rdy = !rst && (q.size() == 0 || (q.size() == 1 && sr));
    chk("batch_ready", 32'(br), 32'(exp_rdy));
    chk("valid", 32'(sv), 32'(q.size() != 0));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (q.size() != 0) begin
      e = q[0];
      chk("data", 32'(sd), 32'(e.d));
      chk("idx", 32'(si), 32'(e.idx));
      chk("last", 32'(sl), 32'(e.last));
    end else begin
      chk("idle_data", 32'(sd), 32'd0);
      chk("idle_idx", 32'(si), 32'd0);
      chk("idle_last", 32'(sl), 32'd0);
    end
    if (rst) begin
      q.delete();
    end else begin
      if (sv && sr && q.size() != 0) void'(q.pop_front());
      if (bv && br) begin
        for (int i = 0; i < 4; i++) begin
          e.d = bd[i]; e.idx = i; e.last = (i == 3);
          q.push_back(e);
        end
      end
    end
  end

  // Scoreboard monitor, 1-word instance: every word is index 0 and last.
  always @(negedge clk) begin
    ent_t e;
    bit   exp_rdy;
    exp_rdy = !rst && (q1.size() == 0 || (q1.size() == 1 && sr1));
    chk("w1_batch_ready", 32'(br1), 32'(exp_rdy));
    chk("w1_valid", 32'(sv1), 32'(q1.size() != 0));
    if (q1.size() != 0) begin
      e = q1[0];
      chk("w1_data", 32'(sd1), 32'(e.d));
      chk("w1_idx", 32'(si1), 32'd0);
      chk("w1_last", 32'(sl1), 32'd1);
    end else begin
      chk("w1_idle_data", 32'(sd1), 32'd0);
      chk("w1_idle_last", 32'(sl1), 32'd0);
    end
    if (rst) begin
      q1.delete();
    end else begin
      if (sv1 && sr1 && q1.size() != 0) begin
        void'(q1.pop_front());
        words1++;
      end
      if (bv1 && br1) begin
        e.d = 16'(bd1[0]); e.idx = 0; e.last = 1'b1;
        q1.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present nxt as a batch and hold it until it is accepted.
  task automatic send_batch();
    bit got;
    got = 0;
    bd = nxt;
    bv = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (br) got = 1;
      step();
    end
    bv = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (q.size() == 0) ok = 1;
      step();
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin bd[i] = '0; nxt[i] = '0; end
    bd1[0] = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single batch, always ready
    sr = 1'b1;
    nxt = '{16'd1, 16'd2, 16'd3, 16'd4};
    send_batch();
    wait_drain();

    // Back-to-back batches, no gap
    nxt = '{16'd1, 16'd2, 16'd3, 16'd4};
    send_batch();
    nxt = '{16'd5, 16'd6, 16'd7, 16'd8};
    send_batch();
    wait_drain();

    // Backpressure on word B
    nxt = '{16'hA, 16'hB, 16'hC, 16'hD};
    send_batch();
    step();
    sr = 1'b0;
    step();
    step();
    sr = 1'b1;
    wait_drain();

    // Input changes while streaming are not seen
    nxt = '{16'd1, 16'd2, 16'd3, 16'd4};
    send_batch();
    nxt = '{16'd9, 16'd9, 16'd9, 16'd9};
    bd = nxt;
    wait_drain();

    // Reset mid-batch, then a fresh batch from index 0
    nxt = '{16'd1, 16'd2, 16'd3, 16'd4};
    send_batch();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    nxt = '{16'd7, 16'd8, 16'd9, 16'd10};
    send_batch();
    wait_drain();

    // Randomized batches against random downstream backpressure
    fork
      begin
        for (int b = 0; b < 40; b++) begin
          for (int i = 0; i < 4; i++) nxt[i] = 16'($urandom);
          repeat ($urandom_range(0, 2)) step();
          send_batch();
        end
        done = 1;
      end
      begin
        while (!done) begin
          step();
          sr = ($urandom_range(0, 3) != 0);
        end
        sr = 1'b1;
      end
    join
    wait_drain();

    // Single-word instance: one batch per cycle
    sr1 = 1'b1;
    bv1 = 1'b1;
    bd1[0] = 8'h11;
    step();
    bd1[0] = 8'h22;
    step();
    bd1[0] = 8'h33;
    step();
    bv1 = 1'b0;
    repeat (3) step();
    chk("w1_word_count", 32'(words1), 32'd3);

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
